// File: rtl/lsu.sv
// Load/store unit: one request at a time, IDLE->BUS->RESP; response 1 cycle after mem_ack (illegal: 1 cycle after accept).
// Backpressure: req_ready only in IDLE; mem_req held stable until mem_ack or TIMEOUT bus cycles elapse.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        rd_mem_en,
    input  logic        wr_mem_en,
    input  logic [7:0]  wr_rd_mem_len,
    input  logic [6:0]  rd_mem_op,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [4:0]  rd,
    output logic        resp_valid,
    output logic [63:0] rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    op_q, op_d;
    logic [2:0]    off_q, off_d;
    logic          load_q, load_d;

    logic          resp_valid_d, mem_req_d, mem_we_d;
    logic [63:0]   rdata_d, mem_addr_d, mem_wdata_d;
    logic [4:0]    resp_rd_d;
    logic [1:0]    resp_err_d;
    logic [7:0]    mem_wmask_d;

    logic          accept, illegal, len_ok, aligned;
    logic [7:0]    op_len, wmask;
    logic [63:0]   shifted, ext;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_ready & req_valid & (rd_mem_en | wr_mem_en);

    // Legality and store lane mask are decided from the live request in IDLE.
    always_comb begin
        len_ok  = 1'b1;
        aligned = 1'b0;
        wmask   = 8'h00;
        op_len  = 8'd0;
        case (wr_rd_mem_len)
            8'd1: begin aligned = 1'b1;               wmask = 8'h01 << addr[2:0]; end
            8'd2: begin aligned = (addr[0] == 1'b0);  wmask = 8'h03 << addr[2:0]; end
            8'd4: begin aligned = (addr[1:0] == 2'd0); wmask = 8'h0F << addr[2:0]; end
            8'd8: begin aligned = (addr[2:0] == 3'd0); wmask = 8'hFF; end
            default: len_ok = 1'b0;
        endcase
        case (rd_mem_op)
            7'b1000000, 7'b0001000: op_len = 8'd1;
            7'b0100000, 7'b0000100: op_len = 8'd2;
            7'b0010000, 7'b0000010: op_len = 8'd4;
            7'b0000001:             op_len = 8'd8;
            default:                op_len = 8'd0;
        endcase
        illegal = (rd_mem_en & wr_mem_en) | ~len_ok | ~aligned |
                  (rd_mem_en & (op_len != wr_rd_mem_len));
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (op_q)
            7'b1000000: ext = {56'd0, shifted[7:0]};
            7'b0100000: ext = {48'd0, shifted[15:0]};
            7'b0010000: ext = {32'd0, shifted[31:0]};
            7'b0001000: ext = {{56{shifted[7]}}, shifted[7:0]};
            7'b0000100: ext = {{48{shifted[15]}}, shifted[15:0]};
            7'b0000010: ext = {{32{shifted[31]}}, shifted[31:0]};
            default:    ext = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        off_d        = off_q;
        load_d       = load_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata;
        resp_rd_d    = resp_rd;
        resp_err_d   = resp_err;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wmask_d  = mem_wmask;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = rd_mem_op;
                    off_d     = addr[2:0];
                    load_d    = rd_mem_en;
                    resp_rd_d = rd;
                    rdata_d   = 64'd0;
                    cnt_d     = '0;
                    if (illegal) begin
                        resp_err_d   = 2'b01;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        resp_err_d  = 2'b00;
                        mem_req_d   = 1'b1;
                        mem_we_d    = wr_mem_en;
                        mem_addr_d  = {addr[63:3], 3'b000};
                        mem_wdata_d = wdata << {addr[2:0], 3'b000};
                        mem_wmask_d = wr_mem_en ? wmask : 8'h00;
                        state_d     = BUS;
                    end
                end
            end
            BUS: begin
                if (mem_ack || cnt_q == CNT_LAST) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wmask_d  = 8'h00;
                    resp_valid_d = 1'b1;
                    resp_err_d   = mem_ack ? 2'b00 : 2'b10;
                    rdata_d      = (mem_ack && load_q) ? ext : 64'd0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= 7'd0;
            off_q      <= 3'd0;
            load_q     <= 1'b0;
            resp_valid <= 1'b0;
            rdata      <= 64'd0;
            resp_rd    <= 5'd0;
            resp_err   <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 64'd0;
            mem_wdata  <= 64'd0;
            mem_wmask  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            off_q      <= off_d;
            load_q     <= load_d;
            resp_valid <= resp_valid_d;
            rdata      <= rdata_d;
            resp_rd    <= resp_rd_d;
            resp_err   <= resp_err_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wmask  <= mem_wmask_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus and response items, a bus responder and a response monitor check them.
module tb_lsu;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic        rd_mem_en = 1'b0, wr_mem_en = 1'b0;
    logic [7:0]  wr_rd_mem_len = 8'd0;
    logic [6:0]  rd_mem_op = 7'd0;
    logic [63:0] addr = 64'd0, wdata = 64'd0;
    logic [4:0]  rd = 5'd0;
    logic        resp_valid;
    logic [63:0] rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .rd_mem_en(rd_mem_en), .wr_mem_en(wr_mem_en), .wr_rd_mem_len(wr_rd_mem_len),
        .rd_mem_op(rd_mem_op), .addr(addr), .wdata(wdata), .rd(rd),
        .resp_valid(resp_valid), .rdata(rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          delay;
        bit          timeout;
        bit          abort;
    } plan_t;

    resp_t resp_q[$];
    plan_t plan_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Load kinds by one-hot bit index: ld, lw, lh, lb, lwu, lhu, lbu.
    function automatic int kind_size(input logic [6:0] op);
        int sz[7];
        int k;
        sz = '{8, 4, 2, 1, 4, 2, 1};
        k = 0;
        for (int i = 0; i < 7; i++) if (op[i]) k = i;
        return sz[k];
    endfunction

    function automatic bit kind_signed(input logic [6:0] op);
        return op[1] | op[2] | op[3];
    endfunction

    function automatic bit legal(input bit re, input bit we, input int len,
                                 input logic [6:0] op, input logic [63:0] a);
        if (re == we) return 0;
        if (!(len inside {1, 2, 4, 8})) return 0;
        if ((a % 64'(len)) != 0) return 0;
        if (re && ($countones(op) != 1 || kind_size(op) != len)) return 0;
        return 1;
    endfunction

    function automatic logic [63:0] load_val(input logic [6:0] op, input logic [63:0] a,
                                             input logic [63:0] w);
        int n, off;
        logic [63:0] v;
        n = kind_size(op);
        off = int'(a % 64'd8);
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (kind_signed(op) && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v;
    endfunction

    task automatic issue(input bit re, input bit we, input int len, input logic [6:0] op,
                         input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r,
                         input logic [63:0] mrd, input int dly, input bit abort);
        int guard;
        int off;
        plan_t p;
        resp_t e;
        guard = 0;
        @(negedge clk);
        while (!req_ready) begin
            // Junk on the request port while busy must never be taken.
            req_valid = 1'($urandom_range(0, 1));
            rd_mem_en = 1'($urandom_range(0, 1));
            wr_mem_en = 1'($urandom_range(0, 1));
            addr      = {$urandom, $urandom};
            wdata     = {$urandom, $urandom};
            rd        = 5'($urandom);
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("FAIL ready_wait: req_ready low for %0d cycles, required high", guard);
                $fatal(1);
            end
        end
        req_valid = 1'b1;
        rd_mem_en = re;
        wr_mem_en = we;
        wr_rd_mem_len = 8'(len);
        rd_mem_op = op;
        addr = a;
        wdata = wd;
        rd = r;
        e.rd = r;
        e.rdata = 64'd0;
        if (!legal(re, we, len, op, a)) begin
            e.err = 2'b01;
            e.cyc = cyc + 1;
            resp_q.push_back(e);
        end else begin
            off = int'(a % 64'd8);
            p.addr = a & ~64'd7;
            p.we = we;
            p.wdata = wd << (8 * off);
            p.wmask = 8'h00;
            if (we) for (int i = 0; i < len; i++) p.wmask[off+i] = 1'b1;
            p.rdata = mrd;
            p.delay = dly;
            p.timeout = (dly >= TIMEOUT);
            p.abort = abort;
            plan_q.push_back(p);
            if (!abort) begin
                if (p.timeout) begin
                    e.err = 2'b10;
                    e.cyc = cyc + 1 + TIMEOUT;
                end else begin
                    e.err = 2'b00;
                    e.cyc = cyc + 2 + dly;
                    if (re) e.rdata = load_val(op, a, mrd);
                end
                resp_q.push_back(e);
            end
        end
    endtask

    // Response monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst && resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp_valid", 64'(resp_valid), 64'd0);
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_rdata", rdata, e.rdata);
                    chk("resp_rd", 64'(resp_rd), 64'(e.rd));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                end
            end
        end
    end

    // Bus responder; also throws stray acks whenever no bus request is outstanding.
    initial begin
        plan_t p;
        int hi;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst && mem_req) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_mem_req", 64'(mem_req), 64'd0);
                end else begin
                    p = plan_q.pop_front();
                    chk("mem_addr", mem_addr, p.addr);
                    chk("mem_we", 64'(mem_we), 64'(p.we));
                    chk("mem_wmask", 64'(mem_wmask), 64'(p.wmask));
                    if (p.we) chk("mem_wdata", mem_wdata, p.wdata);
                    hi = 1;
                    while (hi <= p.delay) begin
                        @(negedge clk);
                        if (!mem_req) break;
                        hi++;
                    end
                    if (p.timeout) begin
                        chk("timeout_req_cycles", 64'(hi), 64'(TIMEOUT));
                    end else if (p.abort) begin
                        repeat (4) @(negedge clk);
                        mem_rdata = {$urandom, $urandom};
                        mem_ack = 1'b1;
                    end else begin
                        chk("req_held_until_ack", {61'd0, mem_req, mem_addr == p.addr,
                            mem_wmask == p.wmask}, 64'd7);
                        mem_rdata = p.rdata;
                        mem_ack = 1'b1;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_rdata = {$urandom, $urandom};
                mem_ack = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int lens[4];
        int len, g;
        bit re, we, s;
        logic [6:0] op;
        logic [63:0] a;
        lens = '{1, 2, 4, 8};

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        rst = 1'b1;

        issue(1, 0, 1, 7'b0001000, 64'h1003, 64'd0, 5'd3, 64'h00000000_80FF0000, 0, 0);
        issue(1, 0, 2, 7'b0100000, 64'h1006, 64'd0, 5'd4, 64'hBEEF0000_00000000, 2, 0);
        issue(0, 1, 2, 7'd0, 64'h2002, 64'h1234, 5'd5, 64'd0, 5, 0);
        issue(1, 0, 4, 7'b0000010, 64'h3002, 64'd0, 5'd6, 64'd0, 0, 0);
        issue(1, 0, 8, 7'b0000001, 64'h4000, 64'd0, 5'd7, 64'd0, 1000, 0);

        for (int t = 0; t < 150; t++) begin
            re = 1'($urandom_range(0, 1));
            we = !re;
            if ($urandom_range(0, 15) == 0) begin re = 1; we = 1; end
            len = lens[$urandom_range(0, 3)];
            if ($urandom_range(0, 15) == 0) len = $urandom_range(0, 20);
            s = 1'($urandom_range(0, 1));
            case (len)
                1: op = s ? 7'b0001000 : 7'b1000000;
                2: op = s ? 7'b0000100 : 7'b0100000;
                4: op = s ? 7'b0000010 : 7'b0010000;
                8: op = 7'b0000001;
                default: op = 7'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            a = {$urandom, $urandom};
            if ((len inside {1, 2, 4, 8}) && $urandom_range(0, 7) != 0) a = a & ~64'(len - 1);
            issue(re, we, len, op, a, {$urandom, $urandom}, 5'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 6), 0);
        end

        // Reset in the middle of a bus access, followed by a late ack.
        issue(1, 0, 8, 7'b0000001, 64'h5000, 64'd0, 5'd9, 64'hDEAD, 20, 1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midbus_rst_mem_req", 64'(mem_req), 64'd0);
        chk("midbus_rst_idle", 64'(req_ready), 64'd1);
        chk("midbus_rst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_no_req", 64'(mem_req), 64'd0);

        issue(1, 0, 4, 7'b0010000, 64'h6004, 64'd0, 5'd11, 64'h89ABCDEF_01234567, 1, 0);
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while ((resp_q.size() != 0 || plan_q.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_resp_queue", 64'(resp_q.size()), 64'd0);
        chk("drain_plan_queue", 64'(plan_q.size()), 64'd0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: maximum cycles in BUS without mem_ack before a bus error is reported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 req_valid  input  1  decoded memory instruction present.
REQ-005 req_ready  output  1  LSU can accept; high only in IDLE.
REQ-006 rd_mem_en / wr_mem_en  input  1 each  load / store request from decoder.
REQ-007 wr_rd_mem_len  input  8  access size in bytes: 1, 2, 4 or 8.
REQ-008 rd_mem_op  input  7  one-hot load kind {lbu,lhu,lwu,lb,lh,lw,ld}, bit6..bit0.
REQ-009 addr  input  64  effective byte address (ALU result).
REQ-010 wdata  input  64  store data (rs2), right-aligned.
REQ-011 rd  input  5  destination register index.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 rdata  output  64  extended load result; 0 for stores and errors.
REQ-014 resp_rd  output  5  captured rd.
REQ-015 resp_err  output  2  00 ok, 01 misaligned/illegal, 10 bus timeout.
REQ-016 mem_req  output  1  bus request; held until mem_ack.
REQ-017 mem_we  output  1  1 = write.
REQ-018 mem_addr  output  64  {addr[63:3],3'b000}.
REQ-019 mem_wdata  output  64  wdata shifted left by 8*addr[2:0].
REQ-020 mem_wmask  output  8  byte-lane enables; 0 for reads.
REQ-021 mem_ack  input  1  bus completion; mem_rdata valid this cycle.
REQ-022 mem_rdata  input  64  aligned 8-byte read word.

Function
REQ-023 FSM states IDLE, BUS, RESP; all outputs registered except req_ready, which is derived from state.
REQ-024 IDLE: request accepted when req_valid & (rd_mem_en | wr_mem_en); addr, wdata, len, op, rd and direction are captured.
REQ-025 Illegal request, checked at accept: both enables set; len not in {1,2,4,8}; addr not len-aligned; load with rd_mem_op not one-hot or inconsistent with len. Any illegal request goes IDLE->RESP with resp_err=01 and no bus access.
REQ-026 Legal request: IDLE->BUS; mem_req=1 from the first BUS cycle and held with stable addr/we/wdata/wmask until mem_ack is sampled high.
REQ-027 mem_wmask for a store: len 1 -> 8'h01<<off; len 2 -> 8'h03<<off; len 4 -> 8'h0F<<off; len 8 -> 8'hFF; off=addr[2:0].
REQ-028 mem_ack in BUS: mem_req drops next cycle; for a load, mem_rdata>>(8*off) is latched and zero- or sign-extended from bit 7/15/31 per rd_mem_op (ld passes through); BUS->RESP.
REQ-029 Timeout: a cycle counter runs in BUS; if it reaches TIMEOUT without mem_ack, mem_req drops, resp_err=10, and BUS->RESP.
REQ-030 RESP: resp_valid=1 for exactly one cycle with rdata/resp_rd/resp_err; RESP->IDLE unconditionally.
REQ-031 Latency: accept at cycle 0, ack in cycle 1 -> resp_valid in cycle 2; an ack in cycle k gives resp_valid in cycle k+1; illegal request -> resp_valid in cycle 1.
REQ-032 mem_ack outside BUS is ignored; req_valid outside IDLE is not accepted.
REQ-033 Store response: rdata=0, resp_err=00; the consumer suppresses register writeback.

Reset
REQ-034 Reset is asserted asynchronously when rst=0, at any time including mid-BUS. State goes to IDLE; mem_req, mem_we, mem_wmask, resp_valid, resp_err, rdata, resp_rd, mem_addr, mem_wdata and the counter all go to 0. req_ready=1 once rst=1.
REQ-035 No pending transaction survives reset; a late mem_ack after reset is ignored.

Verification
REQ-036 lb, addr=0x1003, mem_rdata=0x00000000_80FF0000, ack in cycle 1 -> cycle 2: resp_valid=1, rdata=0xFFFFFFFF_FFFFFF80, resp_err=00.
REQ-037 lhu, addr=0x1006, mem_rdata=0xBEEF0000_00000000 -> rdata=0x00000000_0000BEEF, mem_addr=0x1000.
REQ-038 sh, addr=0x2002, wdata=0x1234 -> mem_we=1, mem_wmask=8'h0C, mem_wdata=0x00000000_12340000; ack delayed 5 cycles with mem_req held -> resp_valid one cycle after ack, rdata=0.
REQ-039 lw, addr=0x3002 -> no mem_req, resp_valid in cycle 1, resp_err=01; ld with no ack, TIMEOUT=255 -> resp_err=10 after 255 BUS cycles, mem_req then 0.
REQ-040 rst driven low mid-BUS -> mem_req=0 and FSM in IDLE immediately; an ack after release produces no resp_valid; the next request completes normally.
